if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS CPU. It holds the program counter, drives the instruction-memory read address, selects the next PC from sequential, branch, jump or register targets, and loads the IF/ID pipeline register that feeds decode. It also applies stall and flush requests from the hazard logic in ID/EX.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000: bubble word loaded into IF/ID on flush or reset (`sll $0,$0,0`).
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: hold the PC and IF/ID contents (load-use hazard).
- `flush` in 1: replace the IF/ID contents with a bubble (taken branch or jump).
- `pc_src` in 2: next-PC select. 00 = PC+4, 01 = `branch_target`, 10 = `jump_target`, 11 = `jr_target`.
- `branch_target` in 32: branch target computed in ID.
- `jump_target` in 32: J/JAL target, already formed as {PC+4[31:28], idx, 2'b00}.
- `jr_target` in 32: register value for JR.
- `imem_addr` out 32: instruction-memory address; equals `pc`, combinational.
- `imem_data` in 32: instruction word; the memory read is asynchronous.
- `pc` out 32: current fetch PC.
- `ifid_instr` out 32: IF/ID instruction.
- `ifid_pc4` out 32: IF/ID PC+4.
- `ifid_valid` out 1: 1 = real instruction, 0 = bubble.

## Operation
- `pc4 = pc + 32'd4`, modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- Next-PC mux is selected by `pc_src`. Bits [1:0] of the selected target are forced to 2'b00, so the PC is always word-aligned.
- Per-edge priority:
  1. `flush`=1 (overrides `stall`):
     - PC ← mux(`pc_src`).
     - `ifid_instr` ← `NOP_INSTR`, `ifid_pc4` ← 0, `ifid_valid` ← 0.
  2. `stall`=1 with `flush`=0: PC and all IF/ID fields hold. `pc_src` is ignored.
  3. Otherwise:
     - PC ← mux(`pc_src`).
     - `ifid_instr` ← `imem_data`, `ifid_pc4` ← `pc4`, `ifid_valid` ← 1.
- `pc_src`≠00 with `flush`=0 is legal: the redirect applies and the fetched word still enters IF/ID. This is the delay-slot style, and it is the hazard unit's choice.
- Reset (`reset`=0, asynchronous, mid-operation included):
  - `pc` = `RESET_PC`.
  - `ifid_instr` = `NOP_INSTR`, `ifid_pc4` = 0, `ifid_valid` = 0.
  - Performance counters = 0.
- The block has no FSM beyond the PC and IF/ID registers. A state bit records "bubble vs valid" (`ifid_valid`).

## Timing
- Fetch-to-IF/ID latency is 1 cycle. `imem_data` must settle within the cycle in which `imem_addr` = `pc`.
- A redirect becomes visible on `pc` one edge after `pc_src`/`flush` are sampled. The target instruction reaches IF/ID on the following edge, so the taken-branch penalty is 1 bubble.
- A stall of N cycles freezes `pc` and IF/ID for exactly N edges. Fetch resumes on the first edge with `stall`=0.
- After `reset` is released, the first rising edge latches `imem_data`@`RESET_PC` and sets `pc` = `RESET_PC`+4.
- `stall` and `flush` are sampled only on `clock` edges. They have no combinational path to the outputs except through `imem_addr` = `pc`.

## Configuration
- Macro: `IF_PERF_CNT_EN`.
- Defined: adds three 32-bit outputs, all wrapping, all cleared by reset.
  - `perf_fetch`: increments on every edge that loads `ifid_valid`=1.
  - `perf_stall`: increments on every edge with `stall`=1 and `flush`=0.
  - `perf_flush`: increments on every edge with `flush`=1.
- Undefined: the ports and counters do not exist. Functional behaviour is identical.

## Structure
- `constants.h` holds:
  - the `pc_src` encodings (`PCSRC_SEQ`, `PCSRC_BR`, `PCSRC_J`, `PCSRC_JR`);
  - `NOP_INSTR`;
  - `clock_period`.
- One sub-module, `next_pc_mux`: combinational 4:1 target select plus low-bit alignment. All registers live in `if_stage`.

## Test plan
- Reset, then free-run with memory words 0x20100009 and 0x20110004 at addresses 0 and 4 → after edge 1, `ifid_instr`=0x20100009, `ifid_pc4`=4, `pc`=4; after edge 2, `ifid_instr`=0x20110004, `pc`=8.
- Assert `stall` for 3 cycles at `pc`=8 → `pc` stays 8 and IF/ID holds 0x20110004 / 4 / valid for 3 edges; fetch resumes at 8.
- `flush`=1, `pc_src`=01, `branch_target`=0x40 → next edge gives `pc`=0x40, `ifid_valid`=0, `ifid_instr`=0; the following edge loads word@0x40.
- `stall`=1 and `flush`=1 together with `pc_src`=10, `jump_target`=0x103 → flush wins: `pc`=0x100 (aligned) and IF/ID holds a bubble.
- Force `pc`=0xFFFF_FFFC via `pc_src`=11, then run sequentially → next `pc`=0, `ifid_pc4`=0.
- Drop `reset` asynchronously mid-cycle while `pc`=0x40 → outputs immediately show `pc`=`RESET_PC` and a bubble in IF/ID; with `IF_PERF_CNT_EN`, all counters read 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: pc_src encodings, reset/bubble words,
// the simulation clock period and the word-alignment helper.
package if_stage_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_JR  = 2'b11
    } pc_src_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
    localparam int          CLOCK_PERIOD  = 10;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-side bus: instruction-memory port plus the IF/ID register outputs toward decode.
interface if_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    modport master (
        output imem_addr,
        input  imem_data,
        output ifid_instr,
        output ifid_pc4,
        output ifid_valid
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  ifid_instr,
        input  ifid_pc4,
        input  ifid_valid
    );
endinterface

// File: rtl/if_stage_next_pc_mux.sv
// Combinational 4:1 next-PC select; the chosen target is forced word-aligned.
module next_pc_mux
    import if_stage_pkg::*;
(
    input  logic [1:0]  pc_src,
    input  logic [31:0] pc4,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] raw_target;

    always_comb begin
        raw_target = pc4;
        case (pc_src)
            PCSRC_SEQ: raw_target = pc4;
            PCSRC_BR:  raw_target = branch_target;
            PCSRC_J:   raw_target = jump_target;
            PCSRC_JR:  raw_target = jr_target;
            default:   raw_target = pc4;
        endcase
    end

    assign next_pc = align_word(raw_target);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional macro IF_PERF_CNT_EN adds fetch/stall/flush performance counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        pc_src,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       jump_target,
    input  logic [31:0]       jr_target,
    output logic [31:0]       pc,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush,
`endif
    if_stage_if.master        bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] pc4;
    logic [31:0] next_pc;

    assign pc4 = pc_q + 32'd4;

    next_pc_mux u_next_pc_mux (
        .pc_src        (pc_src),
        .pc4           (pc4),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .next_pc       (next_pc)
    );

    // Flush beats stall: a redirect must never be lost behind a load-use hold.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (flush) begin
            pc_d         = next_pc;
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = 32'd0;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d         = next_pc;
            ifid_instr_d = bus.imem_data;
            ifid_pc4_d   = pc4;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign pc             = pc_q;
    assign bus.imem_addr  = pc_q;
    assign bus.ifid_instr = ifid_instr_q;
    assign bus.ifid_pc4   = ifid_pc4_q;
    assign bus.ifid_valid = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (flush)
            perf_flush_d = perf_flush_q + 32'd1;
        else if (stall)
            perf_stall_d = perf_stall_q + 32'd1;
        else
            perf_fetch_d = perf_fetch_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall, flush, flush-over-stall, PC wrap,
// delay-slot redirect and asynchronous reset, with hand-computed expectations.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int n_checks;
    int n_errors;

    if_stage_if bus ();

    if_stage dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .pc            (pc),
`ifdef IF_PERF_CNT_EN
        .perf_fetch    (perf_fetch),
        .perf_stall    (perf_stall),
        .perf_flush    (perf_flush),
`endif
        .bus           (bus.master)
    );

    initial clock = 1'b0;
    always #(CLOCK_PERIOD / 2) clock = ~clock;

    // Instruction memory: two program words, one branch-target word, a tagged pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h2010_0009;
            32'h0000_0004: return 32'h2011_0004;
            32'h0000_0040: return 32'h1109_0003;
            default:       return addr ^ 32'h5A5A_0000;
        endcase
    endfunction

    always_comb bus.imem_data = mem_word(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic chk_stage(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid);
        chk({tag, ".pc"},    pc,                 e_pc);
        chk({tag, ".instr"}, bus.ifid_instr,     e_instr);
        chk({tag, ".pc4"},   bus.ifid_pc4,       e_pc4);
        chk({tag, ".valid"}, {31'd0, bus.ifid_valid}, {31'd0, e_valid});
    endtask

    // One rising edge, then settle before checking/driving.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        pc_src        = PCSRC_SEQ;
        branch_target = 32'd0;
        jump_target   = 32'd0;
        jr_target     = 32'd0;

        #3;
        chk_stage("reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("reset.perf_fetch", perf_fetch, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b1;

        step(); chk_stage("e1", 32'h4, 32'h2010_0009, 32'h4, 1'b1);
        step(); chk_stage("e2", 32'h8, 32'h2011_0004, 32'h8, 1'b1);

        stall = 1'b1;
        pc_src = PCSRC_J;            // ignored while stalled
        jump_target = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            step(); chk_stage($sformatf("stall%0d", i), 32'h8, 32'h2011_0004, 32'h8, 1'b1);
        end
        stall = 1'b0;
        pc_src = PCSRC_SEQ;
        step(); chk_stage("resume", 32'hC, 32'h5A5A_0008, 32'hC, 1'b1);

        flush = 1'b1;
        pc_src = PCSRC_BR;
        branch_target = 32'h0000_0040;
        step(); chk_stage("flush", 32'h40, 32'h0, 32'h0, 1'b0);
        flush = 1'b0;
        pc_src = PCSRC_SEQ;
        step(); chk_stage("target", 32'h44, 32'h1109_0003, 32'h44, 1'b1);

        stall = 1'b1;
        flush = 1'b1;
        pc_src = PCSRC_J;
        jump_target = 32'h0000_0103;
        step(); chk_stage("flush_over_stall", 32'h100, 32'h0, 32'h0, 1'b0);

        stall = 1'b0;
        flush = 1'b0;
        pc_src = PCSRC_JR;
        jr_target = 32'hFFFF_FFFE;
        step(); chk_stage("jr", 32'hFFFF_FFFC, 32'h5A5A_0100, 32'h104, 1'b1);
        pc_src = PCSRC_SEQ;
        step(); chk_stage("wrap", 32'h0, 32'hA5A5_FFFC, 32'h0, 1'b1);

        pc_src = PCSRC_BR;
        branch_target = 32'h0000_0040;
        step(); chk_stage("delay_slot", 32'h40, 32'h2010_0009, 32'h4, 1'b1);
        pc_src = PCSRC_SEQ;
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", perf_fetch, 32'd7);
        chk("perf_stall", perf_stall, 32'd3);
        chk("perf_flush", perf_flush, 32'd2);
`endif

        #2;
        reset = 1'b0;
        #1;
        chk_stage("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
        chk("rst.perf_fetch", perf_fetch, 32'd0);
        chk("rst.perf_stall", perf_stall, 32'd0);
        chk("rst.perf_flush", perf_flush, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
        step(); chk_stage("post_reset", 32'h4, 32'h2010_0009, 32'h4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #(CLOCK_PERIOD * 2000);
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
